msx_cart_target: RTL

Cartridge-side responder for the MSX slot bus: the target that answers cycles issued by `msxbus_simple` or a real MSX host. It decodes slot-selected memory cycles, implements an ASCII8-style four-bank mapper over a 2 MB external ROM/flash, stretches reads with WAIT while external memory is fetched, and drives DATA/BUSDIR back onto the bus. It sits between the slot connector pins and the external memory device.

---
 rtl/msx_cart_pkg.sv | 27 ++
 rtl/msx_cart_if.sv | 23 ++
 rtl/msx_bus_sync.sv | 21 ++
 rtl/msx_cart_target.sv | 109 ++++++++++
 4 files changed

// File: rtl/msx_cart_pkg.sv
// rtl/msx_cart_pkg.sv - shared FSM states, address windows and mapper helpers for msx_cart_target
package msx_cart_pkg;

  typedef logic [1:0] cart_state_t;

  localparam cart_state_t ST_IDLE  = 2'd0;
  localparam cart_state_t ST_FETCH = 2'd1;
  localparam cart_state_t ST_DRIVE = 2'd2;
  localparam cart_state_t ST_HOLD  = 2'd3;

  localparam logic [15:0] PAGE_LO    = 16'h4000;
  localparam logic [15:0] PAGE_HI    = 16'hBFFF;
  localparam logic [15:0] BANKREG_LO = 16'h6000;
  localparam logic [15:0] BANKREG_HI = 16'h7FFF;

  // 8 KB page 0x4000 selects bank 0, 0x6000 bank 1, 0x8000 bank 2, 0xA000 bank 3
  function automatic logic [1:0] page_idx(input logic [15:0] addr);
    logic [2:0] p;
    p = addr[15:13] - 3'd2;
    return p[1:0];
  endfunction

  function automatic logic [20:0] map_addr(input logic [7:0] bank, input logic [15:0] addr);
    return {bank, addr[12:0]};
  endfunction

endpackage

// File: rtl/msx_cart_if.sv
// rtl/msx_cart_if.sv - MSX slot bus signals between host (master) and cartridge (slave)
interface msx_cart_if;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        sltsl;
  logic        mreq;
  logic        rd;
  logic        wr;
  logic        wait_n;
  logic        busdir;

  modport master (
    output addr, data_in, sltsl, mreq, rd, wr,
    input  data_out, data_oe, wait_n, busdir
  );

  modport slave (
    input  addr, data_in, sltsl, mreq, rd, wr,
    output data_out, data_oe, wait_n, busdir
  );
endinterface

// File: rtl/msx_bus_sync.sv
// rtl/msx_bus_sync.sv - W-bit two-flop synchronizer for active-low bus strobes (resets to released)
module msx_bus_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/msx_cart_target.sv
// rtl/msx_cart_target.sv - MSX slot target: ASCII8 four-bank mapper, WAIT-stretched external fetch
// MSX_CART_WAIT_EN: when defined, WAIT is pulled low while the external fetch is in progress
module msx_cart_target
  import msx_cart_pkg::*;
#(
  parameter int MEM_AW      = 21,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  msx_cart_if.slave         bus,
  output logic [MEM_AW-1:0] ma,
  input  logic [7:0]        md_in,
  output logic              moe
);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [3:0]  strb_s;
  logic        sltsl_s, mreq_s, rd_s, wr_s;
  logic        rd_prev, wr_prev;
  logic        sel, rd_qual, wr_qual, in_page, in_bankreg;
  cart_state_t state, nxt;
  logic [3:0]  cnt;
  logic [7:0]  bank [4];
  logic [7:0]  data_out_q;
  logic        data_oe_q, busdir_q;

  msx_bus_sync #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({bus.sltsl, bus.mreq, bus.rd, bus.wr}),
    .q   (strb_s)
  );

  assign {sltsl_s, mreq_s, rd_s, wr_s} = strb_s;

  assign sel        = ~sltsl_s & ~mreq_s;
  assign in_page    = (bus.addr >= PAGE_LO) && (bus.addr <= PAGE_HI);
  assign in_bankreg = (bus.addr >= BANKREG_LO) && (bus.addr <= BANKREG_HI);
  assign rd_qual    = sel & rd_prev & ~rd_s & in_page;
  assign wr_qual    = sel & wr_prev & ~wr_s;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (rd_qual)      nxt = ST_FETCH;
        else if (wr_qual) nxt = ST_HOLD;
      end
      ST_FETCH: begin
        if (sltsl_s | rd_s) nxt = ST_IDLE;
        else if (cnt == 4'd0) nxt = ST_DRIVE;
      end
      ST_DRIVE: if (sltsl_s | rd_s) nxt = ST_IDLE;
      ST_HOLD:  if (wr_s) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // the pad stays driven for one edge after DRIVE exits so the host sees a clean turnaround
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rd_prev    <= 1'b1;
      wr_prev    <= 1'b1;
      cnt        <= '0;
      ma         <= '0;
      moe        <= 1'b1;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
      busdir_q   <= 1'b1;
      for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
    end else begin
      state     <= nxt;
      rd_prev   <= rd_s;
      wr_prev   <= wr_s;
      moe       <= (nxt != ST_FETCH);
      data_oe_q <= (nxt == ST_DRIVE) || (state == ST_DRIVE);
      busdir_q  <= !((nxt == ST_DRIVE) || (state == ST_DRIVE));
      if (state == ST_IDLE && rd_qual) begin
        ma  <= MEM_AW'(map_addr(bank[page_idx(bus.addr)], bus.addr));
        cnt <= CNT_LOAD;
      end else if (state == ST_FETCH && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ST_FETCH && nxt == ST_DRIVE) data_out_q <= md_in;
      if (state == ST_IDLE && !rd_qual && wr_qual && in_bankreg)
        bank[bus.addr[12:11]] <= bus.data_in;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.data_oe  = data_oe_q;
  assign bus.busdir   = busdir_q;

`ifdef MSX_CART_WAIT_EN
  logic wait_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) wait_q <= 1'b1;
    else     wait_q <= (nxt != ST_FETCH);
  end

  assign bus.wait_n = wait_q;
`else
  assign bus.wait_n = 1'b1;
`endif

endmodule
